// File: rtl/ifetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifetch_prefetch_queue_pkg;

  typedef logic [15:0] instr_t;
  typedef logic [15:0] addr_t;

  localparam addr_t PC_INC = 16'd2;

endpackage

// File: rtl/ifetch_prefetch_queue_iq_fifo.sv
// Instruction word FIFO with flush; pop data is the current head, read combinationally.
module iq_fifo
  import ifetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  instr_t                 push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output instr_t                 pop_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  instr_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential Avalon-MM reads ahead of the CPU,
// serves hits from the queue and handles redirects by dropping in-flight responses.
module ifetch_prefetch_queue
  import ifetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_pc_addr,
  input  logic        cpu_pc_rd,
  output logic [15:0] cpu_rddata,
  output logic        cpu_valid,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [15:0] mem_readdata,
  input  logic        mem_readdatavalid
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] outs_q, outs_d;
  logic [CW-1:0] drop_q, drop_d;
  addr_t         head_q, head_d;
  addr_t         fetch_q, fetch_d;
  addr_t         mem_addr_q, mem_addr_d;
  addr_t         target;
  instr_t        pop_data;
  instr_t        rddata_q, rddata_d;
  logic          mem_read_q, mem_read_d;
  logic          stale_q, stale_d;
  logic          valid_q, valid_d;
  logic          accept, hold, redirect, hit, drop_resp, live_resp, bypass, push;

  iq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (mem_readdata),
    .pop_i       (hit),
    .flush_i     (redirect),
    .pop_data_o  (pop_data),
    .count_o     (count)
  );

  // Odd PCs are normalised before comparison so a CPU holding an odd address
  // redirects once and then waits as a sequential miss instead of re-flushing.
  assign target    = {cpu_pc_addr[15:1], 1'b0};
  assign redirect  = cpu_pc_rd && (target != head_q);
  assign accept    = mem_read_q && !mem_waitrequest;
  assign hold      = mem_read_q && mem_waitrequest;
  assign hit       = cpu_pc_rd && !redirect && (count != '0);
  assign drop_resp = mem_readdatavalid && ((drop_q != '0) || redirect);
  assign live_resp = mem_readdatavalid && !drop_resp;
  assign bypass    = live_resp && cpu_pc_rd && !redirect && (count == '0);
  assign push      = live_resp && !bypass;

  always_comb begin
    outs_d  = outs_q + CW'(accept) - CW'(mem_readdatavalid);
    cnt_nxt = redirect ? '0 : (count + CW'(push) - CW'(hit));

    fetch_d = fetch_q;
    if (redirect)              fetch_d = target;
    else if (accept && !stale_q) fetch_d = fetch_q + PC_INC;

    // A stale command accepted after its redirect carries the old address;
    // it is counted into drop when it is finally accepted.
    if (redirect) drop_d = outs_d;
    else          drop_d = drop_q - CW'(mem_readdatavalid && (drop_q != '0)) + CW'(accept && stale_q);

    head_d = head_q;
    if (redirect)          head_d = target;
    else if (hit || bypass) head_d = head_q + PC_INC;

    valid_d  = hit || bypass;
    rddata_d = rddata_q;
    if (hit)         rddata_d = pop_data;
    else if (bypass) rddata_d = mem_readdata;

    if (hold) begin
      mem_read_d = 1'b1;
      mem_addr_d = mem_addr_q;
      stale_d    = stale_q || redirect;
    end else begin
      mem_read_d = ({1'b0, cnt_nxt} + {1'b0, outs_d}) < (CW+1)'(DEPTH);
      mem_addr_d = fetch_d;
      stale_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outs_q     <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      fetch_q    <= '0;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      stale_q    <= 1'b0;
      valid_q    <= 1'b0;
      rddata_q   <= '0;
    end else begin
      outs_q     <= outs_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      fetch_q    <= fetch_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      stale_q    <= stale_d;
      valid_q    <= valid_d;
      rddata_q   <= rddata_d;
    end
  end

  assign cpu_valid  = valid_q;
  assign cpu_rddata = rddata_q;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed bench for ifetch_prefetch_queue; memory returns mem[a] = a + 0x1000.
module tb_ifetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_pc_addr = '0;
  logic        cpu_pc_rd = 1'b0;
  logic [15:0] cpu_rddata;
  logic        cpu_valid;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [15:0] mem_readdata;
  logic        mem_readdatavalid;

  int checks = 0;
  int failures = 0;

  logic [1:0]  lat_sel = 2'd0;
  logic [3:0]  pv;
  logic [15:0] pa [4];
  int unsigned acc_cnt = 0;
  logic [15:0] acc_log [64];

  ifetch_prefetch_queue #(.DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_pc_addr       (cpu_pc_addr),
    .cpu_pc_rd         (cpu_pc_rd),
    .cpu_rddata        (cpu_rddata),
    .cpu_valid         (cpu_valid),
    .mem_addr          (mem_addr),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid)
  );

  always #5 clk = ~clk;

  // Memory model: fixed latency of lat_sel+1 cycles, in-order, reset with the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) pv <= '0;
    else begin
      pv    <= {pv[2:0], mem_read & ~mem_waitrequest};
      pa[0] <= mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end
  assign mem_readdatavalid = pv[lat_sel];
  assign mem_readdata      = pa[lat_sel] + 16'h1000;

  always @(posedge clk) begin
    if (!reset && mem_read && !mem_waitrequest) begin
      acc_log[acc_cnt[5:0]] <= mem_addr;
      acc_cnt <= acc_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] lat);
    reset = 1'b1;
    cpu_pc_rd = 1'b0;
    cpu_pc_addr = '0;
    mem_waitrequest = 1'b0;
    lat_sel = lat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic req(input logic [15:0] a);
    cpu_pc_rd = 1'b1;
    cpu_pc_addr = a;
  endtask

  task automatic wait_valid(input string tag, input int bound, output int waited);
    waited = 0;
    while (waited < bound) begin
      tick();
      waited++;
      if (cpu_valid === 1'b1) break;
    end
    chk(tag, 32'(cpu_valid), 32'd1);
  endtask

  initial begin
    int w;
    int unsigned base;

    // Reset values
    #12;
    chk("rst_valid", 32'(cpu_valid), 32'd0);
    chk("rst_rddata", 32'(cpu_rddata), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);

    // Back-to-back sequential fetch from reset, zero-wait memory
    @(negedge clk);
    reset = 1'b0;
    req(16'h0000);
    tick();
    chk("a_first_read", 32'(mem_read), 32'd1);
    chk("a_first_addr", 32'(mem_addr), 32'h0000);
    wait_valid("a_v0", 10, w);
    chk("a_lat0", 32'(w + 1), 32'd3);
    chk("a_d0", 32'(cpu_rddata), 32'h1000);
    req(16'h0002);
    wait_valid("a_v1", 10, w);
    chk("a_lat1", 32'(w), 32'd1);
    chk("a_d1", 32'(cpu_rddata), 32'h1002);
    req(16'h0004);
    wait_valid("a_v2", 10, w);
    chk("a_lat2", 32'(w), 32'd1);
    chk("a_d2", 32'(cpu_rddata), 32'h1004);
    cpu_pc_rd = 1'b0;
    tick();
    chk("a_pulse", 32'(cpu_valid), 32'd0);
    chk("a_hold_data", 32'(cpu_rddata), 32'h1004);

    // Queue fills while the CPU is idle
    do_reset(2'd0);
    base = acc_cnt;
    repeat (12) tick();
    chk("b_accepts", acc_cnt - base, 32'd4);
    for (int i = 0; i < 4; i++)
      chk("b_acc_addr", 32'(acc_log[6'(base + i)]), 32'(2 * i));
    chk("b_read_off", 32'(mem_read), 32'd0);
    chk("b_idle_valid", 32'(cpu_valid), 32'd0);
    req(16'h0000);
    wait_valid("b_v0", 10, w);
    chk("b_d0", 32'(cpu_rddata), 32'h1000);
    chk("b_refill_read", 32'(mem_read), 32'd1);
    chk("b_refill_addr", 32'(mem_addr), 32'h0008);
    for (int i = 1; i < 5; i++) begin
      req(16'(2 * i));
      wait_valid("b_vn", 10, w);
      chk("b_dn", 32'(cpu_rddata), 32'(16'h1000 + 16'(2 * i)));
    end
    cpu_pc_rd = 1'b0;

    // Redirect with two reads in flight, 3-cycle memory latency
    do_reset(2'd2);
    tick();
    tick();
    req(16'h0100);
    tick();
    chk("c_redir_read", 32'(mem_read), 32'd1);
    chk("c_redir_addr", 32'(mem_addr), 32'h0100);
    tick();
    chk("c_next_addr", 32'(mem_addr), 32'h0102);
    chk("c_no_valid", 32'(cpu_valid), 32'd0);
    wait_valid("c_v0", 12, w);
    chk("c_d0", 32'(cpu_rddata), 32'h1100);
    req(16'h0102);
    wait_valid("c_v1", 12, w);
    chk("c_d1", 32'(cpu_rddata), 32'h1102);
    cpu_pc_rd = 1'b0;

    // Redirect while the command is stalled by waitrequest
    do_reset(2'd0);
    tick();
    mem_waitrequest = 1'b1;
    req(16'h0200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_hold_read", 32'(mem_read), 32'd1);
      chk("d_hold_addr", 32'(mem_addr), 32'h0000);
    end
    mem_waitrequest = 1'b0;
    tick();
    chk("d_new_addr", 32'(mem_addr), 32'h0200);
    wait_valid("d_v0", 12, w);
    chk("d_d0", 32'(cpu_rddata), 32'h1200);
    cpu_pc_rd = 1'b0;

    // Address wrap 0xFFFE -> 0x0000, then odd-address redirect
    do_reset(2'd0);
    req(16'hFFFE);
    wait_valid("e_v0", 10, w);
    chk("e_d0", 32'(cpu_rddata), 32'h0FFE);
    req(16'h0000);
    wait_valid("e_v1", 10, w);
    chk("e_lat1", 32'(w), 32'd1);
    chk("e_d1", 32'(cpu_rddata), 32'h1000);
    req(16'h0301);
    wait_valid("e_v2", 12, w);
    chk("e_odd", 32'(cpu_rddata), 32'h1300);
    cpu_pc_rd = 1'b0;

    // Reset with 3 queued entries and 1 outstanding read
    do_reset(2'd0);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("f_valid", 32'(cpu_valid), 32'd0);
    chk("f_rddata", 32'(cpu_rddata), 32'h0);
    chk("f_mem_read", 32'(mem_read), 32'd0);
    chk("f_mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req(16'h0000);
    wait_valid("f_v0", 10, w);
    chk("f_lat", 32'(w), 32'd3);
    chk("f_d0", 32'(cpu_rddata), 32'h1000);
    cpu_pc_rd = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
